// File: rtl/rpi_link_tx_pkg.sv
// Shared types and constants for the Raspberry Pi parallel link transmitter.
package rpi_link_tx_pkg;

  localparam int SETUP_CYCLES_DEF = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_A_SETUP = 3'd1;
  localparam logic [2:0] ST_A_HOLD  = 3'd2;
  localparam logic [2:0] ST_D_SETUP = 3'd3;
  localparam logic [2:0] ST_D_HIGH  = 3'd4;
  localparam logic [2:0] ST_D_LOW   = 3'd5;
  localparam logic [2:0] ST_A_END   = 3'd6;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } link_entry_t;

endpackage

// File: rtl/rpi_link_tx_fifo.sv
// Synchronous FIFO of {addr, data} entries with occupancy, full flag and sticky overflow.
module link_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [15:0]              i_entry,
  input  logic                     i_pop,
  output logic [15:0]              o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/rpi_link_tx.sv
// Link transmitter: buffers {addr, data} entries and sends them to the Pi as
// address-strobed frames of data-strobed bytes with a four-phase ACK handshake.
module rpi_link_tx
  import rpi_link_tx_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int SETUP_CYCLES = SETUP_CYCLES_DEF
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         WR_EN,
  input  logic [7:0]                   WR_ADDR,
  input  logic [7:0]                   WR_DATA,
  output logic                         FULL,
  output logic [$clog2(FIFO_DEPTH):0]  COUNT,
  output logic                         OVERFLOW,
  output logic [7:0]                   TX_D,
  output logic                         TX_AS,
  output logic                         TX_DS,
  input  logic                         RPI_ACK
);

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

  logic        r_ack_s1;
  logic        r_ack_s2;
  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [7:0]  r_addr;
  logic [7:0]  r_tx_d;
  logic        r_as;
  logic        r_ds;
  logic [15:0] w_head_raw;
  link_entry_t w_head;
  logic        w_empty;
  logic        w_pop;
  logic        w_timer_done;

  link_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_push     (WR_EN),
    .i_entry    ({WR_ADDR, WR_DATA}),
    .i_pop      (w_pop),
    .o_head     (w_head_raw),
    .o_count    (COUNT),
    .o_full     (FULL),
    .o_empty    (w_empty),
    .o_overflow (OVERFLOW)
  );

  assign w_head       = w_head_raw;
  assign w_timer_done = (r_cnt == SETUP_LAST);
  // The head byte leaves the FIFO exactly when its strobe is released.
  assign w_pop        = (r_state == ST_D_HIGH) && r_ack_s2;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_tx_d   <= '0;
      r_as     <= 1'b0;
      r_ds     <= 1'b0;
    end else begin
      r_ack_s1 <= RPI_ACK;
      r_ack_s2 <= r_ack_s1;
      case (r_state)
        ST_IDLE: if (!w_empty) begin
          r_tx_d  <= w_head.addr;
          r_addr  <= w_head.addr;
          r_cnt   <= '0;
          r_state <= ST_A_SETUP;
        end
        ST_A_SETUP: if (w_timer_done) begin
          r_as    <= 1'b1;
          r_cnt   <= '0;
          r_state <= ST_A_HOLD;
        end else r_cnt <= r_cnt + 1'b1;
        ST_A_HOLD: if (w_timer_done) begin
          r_tx_d  <= w_head.data;
          r_cnt   <= '0;
          r_state <= ST_D_SETUP;
        end else r_cnt <= r_cnt + 1'b1;
        ST_D_SETUP: if (w_timer_done) begin
          r_ds    <= 1'b1;
          r_state <= ST_D_HIGH;
        end else r_cnt <= r_cnt + 1'b1;
        ST_D_HIGH: if (r_ack_s2) begin
          r_ds    <= 1'b0;
          r_state <= ST_D_LOW;
        end
        // Same-address successors stay inside the current AS frame as a burst.
        ST_D_LOW: if (!r_ack_s2) begin
          r_cnt <= '0;
          if (!w_empty && (w_head.addr == r_addr)) begin
            r_tx_d  <= w_head.data;
            r_state <= ST_D_SETUP;
          end else begin
            r_state <= ST_A_END;
          end
        end
        ST_A_END: if (w_timer_done) begin
          r_as    <= 1'b0;
          r_state <= ST_IDLE;
        end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign TX_D  = r_tx_d;
  assign TX_AS = r_as;
  assign TX_DS = r_ds;

endmodule

// File: tb/tb_rpi_link_tx.sv
// Bench for rpi_link_tx: transaction-level scoreboard, ACK responder and directed/random steps.
module tb_rpi_link_tx;

  localparam int DEPTH = 16;
  localparam int SETUP = 4;

  logic       CLK;
  logic       RESET;
  logic       WR_EN;
  logic [7:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       FULL;
  logic [4:0] COUNT;
  logic       OVERFLOW;
  logic [7:0] TX_D;
  logic       TX_AS;
  logic       TX_DS;
  logic       RPI_ACK;

  rpi_link_tx #(.FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP)) dut (
    .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .FULL(FULL), .COUNT(COUNT), .OVERFLOW(OVERFLOW), .TX_D(TX_D), .TX_AS(TX_AS),
    .TX_DS(TX_DS), .RPI_ACK(RPI_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // ACK responder: ack_en enables it, ack_rand picks 0..5 cycle delays, else ack_delay.
  logic ack_force = 1'b0;
  logic ack_resp  = 1'b0;
  logic ack_en    = 1'b0;
  logic ack_rand  = 1'b0;
  int   ack_delay = 0;
  int   ack_cnt   = 0;
  int   ack_rnd   = 0;
  assign RPI_ACK = ack_force | ack_resp;

  always @(negedge CLK) begin
    if (RESET || !ack_en) begin
      ack_resp = 1'b0;
      ack_cnt  = 0;
    end else if (TX_DS && !ack_resp) begin
      if (ack_cnt >= (ack_rand ? ack_rnd : ack_delay)) begin
        ack_resp = 1'b1;
        ack_cnt  = 0;
        ack_rnd  = $urandom_range(0, 5);
      end else begin
        ack_cnt++;
      end
    end else if (!TX_DS && ack_resp) begin
      ack_resp = 1'b0;
    end
  end

  // Reference model: occupancy, overflow, and the ordered list of accepted entries.
  logic [15:0] exp_q[$];
  int   m_count = 0;
  bit   m_ovf   = 0;
  logic prev_as = 1'b0;
  logic prev_ds = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic [7:0] frame_addr = 8'h00;
  int   as_rises = 0, ds_pulses = 0, ds_len = 0, last_ds_len = 0;
  int   sb_err = 0, cnt_err = 0, stab_err = 0, frm_err = 0, rst_err = 0;

  always begin
    logic        push_s;
    logic [15:0] push_e;
    logic [15:0] e;
    bit          pop;
    @(posedge CLK);
    push_s = WR_EN;
    push_e = {WR_ADDR, WR_DATA};
    #1;
    if (RESET) begin
      exp_q.delete();
      m_count = 0; m_ovf = 0;
      prev_as = 1'b0; prev_ds = 1'b0; prev_d = 8'h00; ds_len = 0;
      if ({TX_AS, TX_DS, TX_D, COUNT, FULL, OVERFLOW} !== 17'd0) rst_err++;
    end else begin
      pop = prev_ds && !TX_DS;
      if (push_s) begin
        if (m_count < DEPTH || pop) begin
          exp_q.push_back(push_e);
          m_count++;
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) m_count--;
      if ({COUNT, FULL, OVERFLOW} !== {5'(m_count), m_count == DEPTH, m_ovf}) begin
        cnt_err++;
        $display("note: occupancy obs=%0d/%0b/%0b exp=%0d/%0b/%0b",
                 COUNT, FULL, OVERFLOW, m_count, m_count == DEPTH, m_ovf);
      end
      if ((TX_AS !== prev_as || TX_DS !== prev_ds) && TX_D !== prev_d) stab_err++;
      if (TX_AS && !prev_as) begin
        frame_addr = TX_D;
        as_rises++;
      end
      if (TX_DS && !prev_ds) begin
        ds_pulses++;
        if (!TX_AS) frm_err++;
        if (exp_q.size() == 0) begin
          sb_err++;
          $display("note: unexpected strobe addr=%0h data=%0h", frame_addr, TX_D);
        end else begin
          e = exp_q.pop_front();
          if ({frame_addr, TX_D} !== e) begin
            sb_err++;
            $display("note: entry obs=%0h exp=%0h", {frame_addr, TX_D}, e);
          end
        end
      end
      if (TX_DS) ds_len++;
      else if (prev_ds) begin
        last_ds_len = ds_len;
        ds_len = 0;
      end
      prev_as = TX_AS; prev_ds = TX_DS; prev_d = TX_D;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic push(input logic [7:0] a, input logic [7:0] d);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(TX_AS == 1'b0 && TX_DS == 1'b0 && COUNT == 5'd0 && exp_q.size() == 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_ds(input string tag, input int budget);
    int n = 0;
    while (!TX_DS && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(TX_DS), 32'd1);
  endtask

  task automatic check_monitor(input string tag);
    check({tag, "_sb"},   32'(sb_err),   32'd0);
    check({tag, "_occ"},  32'(cnt_err),  32'd0);
    check({tag, "_stab"}, 32'(stab_err), 32'd0);
    check({tag, "_frm"},  32'(frm_err),  32'd0);
    check({tag, "_rst"},  32'(rst_err),  32'd0);
  endtask

  initial begin
    int n;
    int base_as, base_ds;
    RESET = 1'b1; WR_EN = 1'b0; WR_ADDR = 8'h00; WR_DATA = 8'h00;
    ack_en = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_as", 32'(TX_AS), 32'd0);
    check("reset_count", 32'(COUNT), 32'd0);
    check("reset_txd", 32'(TX_D), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Single entry, immediate ACK, plus push-to-AS latency.
    push(8'h01, 8'h55);
    n = 0;
    while (!TX_AS && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    check("as_latency", 32'(n), 32'(1 + SETUP));
    @(negedge CLK);
    wait_idle("single_idle", 300);
    check("single_as", 32'(as_rises), 32'd1);
    check("single_ds", 32'(ds_pulses), 32'd1);
    check_monitor("single");

    // Burst under one frame, then a second frame.
    base_as = as_rises; base_ds = ds_pulses;
    push(8'h01, 8'hAA);
    push(8'h01, 8'hBB);
    push(8'h02, 8'hCC);
    wait_idle("burst_idle", 500);
    check("burst_as", 32'(as_rises - base_as), 32'd2);
    check("burst_ds", 32'(ds_pulses - base_ds), 32'd3);
    check_monitor("burst");

    // Overfill with ACK held low.
    ack_en = 1'b0;
    for (int i = 0; i < 17; i++) push(8'h20, 8'($urandom));
    wait_ds("ovf_ds", 100);
    repeat (50) @(negedge CLK);
    check("ovf_full", 32'(FULL), 32'd1);
    check("ovf_flag", 32'(OVERFLOW), 32'd1);
    check("ovf_count", 32'(COUNT), 32'd16);
    check("ovf_stall_ds", 32'(TX_DS), 32'd1);
    check_monitor("ovf");

    // Asynchronous reset mid-strobe.
    RESET = 1'b1;
    #1;
    check("rst_as", 32'(TX_AS), 32'd0);
    check("rst_ds", 32'(TX_DS), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_ovf", 32'(OVERFLOW), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    base_as = as_rises;
    repeat (30) @(negedge CLK);
    check("rst_no_resume", 32'(as_rises - base_as), 32'd0);
    check("rst_quiet_ds", 32'(TX_DS), 32'd0);

    // Push coinciding with pop while full.
    for (int i = 0; i < 16; i++) push(8'h30, 8'(i));
    wait_ds("pp_ds", 100);
    check("pp_full_before", 32'(FULL), 32'd1);
    ack_force = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    WR_EN = 1'b1; WR_ADDR = 8'h30; WR_DATA = 8'hEE;
    @(posedge CLK); #1;
    check("pp_count", 32'(COUNT), 32'd16);
    check("pp_ovf", 32'(OVERFLOW), 32'd0);
    check("pp_popped", 32'(TX_DS), 32'd0);
    @(negedge CLK);
    WR_EN = 1'b0;
    ack_force = 1'b0;
    ack_en = 1'b1;
    wait_idle("pp_idle", 2000);
    check_monitor("pp");

    // Slow ACK.
    ack_delay = 100;
    base_ds = ds_pulses;
    push(8'h40, 8'h77);
    wait_idle("slow_idle", 600);
    check("slow_ds_count", 32'(ds_pulses - base_ds), 32'd1);
    check("slow_ds_len", 32'(last_ds_len >= 100), 32'd1);
    ack_delay = 0;
    check_monitor("slow");

    // Randomized traffic with random ACK delays.
    ack_rand = 1'b1;
    base_ds = ds_pulses;
    for (int i = 0; i < 400; i++) begin
      WR_EN   = ($urandom_range(0, 3) == 0);
      WR_ADDR = 8'h50 + 8'($urandom_range(0, 1));
      WR_DATA = 8'($urandom);
      @(negedge CLK);
    end
    WR_EN = 1'b0;
    wait_idle("rand_idle", 4000);
    check("rand_traffic", 32'(ds_pulses > base_ds), 32'd1);
    check_monitor("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rpi_link_tx.md
RPI_LINK_TX -- requirements
Module: rpi_link_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 16 (power of two, 4..64): number of buffered {address, data} entries.
REQ-002 Parameter SETUP_CYCLES, default 4 (1..15): CLK cycles that TX_D is held stable before any strobe edge.
REQ-003 CLK  input  1  system clock; the only clock.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 WR_EN  input  1  push request; one entry per cycle while high.
REQ-006 WR_ADDR  input  8  channel address of the pushed entry.
REQ-007 WR_DATA  input  8  payload byte of the pushed entry.
REQ-008 FULL  output  1  FIFO holds FIFO_DEPTH entries.
REQ-009 COUNT  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 OVERFLOW  output  1  sticky flag: a push was dropped.
REQ-011 TX_D  output  8  link data lines to the Pi, carrying the address or the data byte.
REQ-012 TX_AS  output  1  address strobe; rising edge means TX_D holds the address; high for the whole frame.
REQ-013 TX_DS  output  1  data strobe; each high pulse carries one data byte on TX_D.
REQ-014 RPI_ACK  input  1  Pi acknowledge; asynchronous, 2-FF synchronised internally.

Function
REQ-015 The FIFO shall accept a push when WR_EN=1 and FULL=0; a simultaneous push and pop while full shall accept the push.
REQ-016 A push with FULL=1 and no pop in that cycle shall be dropped and shall set OVERFLOW.
REQ-017 The link FSM states shall be IDLE, A_SETUP, A_HOLD, D_SETUP, D_HIGH, D_LOW, A_END.
REQ-018 IDLE: when FIFO is non-empty, drive TX_D=head.addr and go to A_SETUP.
REQ-019 A_SETUP: after SETUP_CYCLES cycles, set TX_AS=1 and go to A_HOLD.
REQ-020 A_HOLD: after SETUP_CYCLES cycles, drive TX_D=head.data and go to D_SETUP.
REQ-021 D_SETUP: after SETUP_CYCLES cycles, set TX_DS=1 and go to D_HIGH.
REQ-022 D_HIGH: wait for synchronised RPI_ACK=1, then set TX_DS=0, pop the head entry and go to D_LOW.
REQ-023 D_LOW: wait for synchronised RPI_ACK=0. Then, if the FIFO is non-empty and the new head.addr equals the current frame address, drive TX_D=head.data and go to D_SETUP (burst); otherwise go to A_END.
REQ-024 A_END: after SETUP_CYCLES cycles, set TX_AS=0 and go to IDLE; TX_D keeps its last value.
REQ-025 Each data byte shall be popped exactly once, only on the D_HIGH to D_LOW transition; no byte shall be duplicated or skipped.
REQ-026 There shall be no ACK timeout: the FSM shall wait indefinitely in D_HIGH or D_LOW.
REQ-027 TX_AS and TX_DS shall be registered outputs, glitch-free, and shall never change in the same cycle as TX_D.
REQ-028 The minimum latency from push into an empty FIFO to TX_AS rising shall be 1+SETUP_CYCLES cycles.
REQ-029 FIFO pointers shall wrap modulo FIFO_DEPTH; COUNT shall be computed with one extra bit so full and empty are distinct.

Reset
REQ-030 While RESET=1: TX_AS=0, TX_DS=0, TX_D=0, FIFO empty, COUNT=0, FULL=0, OVERFLOW=0, FSM=IDLE, ACK synchroniser=0.
REQ-031 Reset asserted mid-frame shall drop strobes immediately (asynchronously), discard all buffered entries, and not resume the frame.

Structure
REQ-032 The shared package shall hold the FSM state enumeration, the link entry type {addr[7:0], data[7:0]}, and the SETUP_CYCLES default constant.
REQ-033 One sub-module, link_fifo (synchronous FIFO with COUNT/FULL), shall be instantiated; the FSM and the ACK synchroniser shall be in rpi_link_tx.

Verification
REQ-034 Push {01,55} with an immediate ACK responder -> TX_AS rises with TX_D=01, one TX_DS pulse with TX_D=55, TX_AS falls, COUNT returns to 0.
REQ-035 Push {01,AA},{01,BB},{02,CC} -> frame 1 has two DS pulses (AA, BB) under one AS; frame 2 has AS with TX_D=02 and one pulse with CC.
REQ-036 Push 17 entries with ACK held low and FIFO_DEPTH=16 -> FULL=1, OVERFLOW=1, COUNT=16; FSM stalls in D_HIGH with TX_DS=1.
REQ-037 Assert RESET while TX_DS=1 -> TX_AS=TX_DS=0 in the same cycle; COUNT=0; no strobe activity after release until a new push.
REQ-038 Push and pop in the same cycle while FULL=1 -> push accepted, COUNT stays 16, OVERFLOW stays 0.
REQ-039 Delay ACK by 100 cycles -> TX_DS stays high for at least 100 cycles; exactly one pop occurs per pulse.
